// File: rtl/lif_neuron_reader_pkg.sv
// Shared constants, FSM state encoding and saturating arithmetic helpers
// for the leaky integrate-and-fire neuron and its weight scanner.
package snn_pkg;

   localparam int N_SYN = 16;
   localparam int W_W   = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      DRAIN  = 3'd2,
      UPDATE = 3'd3,
      REFR   = 3'd4
   } lif_state_t;

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_v}) begin
         return max_v;
      end else begin
         return sum[31:0];
      end
   endfunction

   function automatic logic [31:0] floor_sub(input logic [31:0] a,
                                             input logic [31:0] b);
      if (a > b) begin
         return a - b;
      end else begin
         return 32'd0;
      end
   endfunction

endpackage

// File: rtl/lif_neuron_reader_if.sv
// Timestep handshake, weight read port and neuron status bundle.
// The neuron is the slave; the environment (learner / bench) is the master.
interface lif_neuron_reader_if #(
   parameter int N_SYN = 16,
   parameter int W_W   = 4,
   parameter int V_W   = 10
);
   localparam int AW = $clog2(N_SYN);

   logic             step_valid;
   logic             step_ready;
   logic [N_SYN-1:0] pre_spikes;
   logic             weight_rd_en;
   logic [AW-1:0]    weight_rd_addr;
   logic [W_W-1:0]   weight_rd_data;
   logic             post_spike;
   logic [V_W-1:0]   membrane;
   logic             refractory;

   modport slave (
      input  step_valid, pre_spikes, weight_rd_data,
      output step_ready, weight_rd_en, weight_rd_addr, post_spike, membrane, refractory
   );

   modport master (
      output step_valid, pre_spikes, weight_rd_data,
      input  step_ready, weight_rd_en, weight_rd_addr, post_spike, membrane, refractory
   );
endinterface

// File: rtl/lif_neuron_reader_scan.sv
// Walks the weight array once per start pulse and sums the weights of the
// synapses whose latched presynaptic spike bit is set (1-cycle read latency).
module weight_scan_acc #(
   parameter int N_SYN = snn_pkg::N_SYN,
   parameter int W_W   = snn_pkg::W_W,
   parameter int ACC_W = $clog2(N_SYN * ((1 << W_W) - 1) + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [N_SYN-1:0]         spk_i,
   output logic                     rd_en_o,
   output logic [$clog2(N_SYN)-1:0] rd_addr_o,
   input  logic [W_W-1:0]           rd_data_i,
   output logic                     last_o,
   output logic                     done_o,
   output logic [ACC_W-1:0]         acc_o
);
   localparam int AW = $clog2(N_SYN);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N_SYN - 1);

   logic          rd_en_q;
   logic [AW-1:0] addr_q;
   logic          en_d1_q;
   logic [AW-1:0] addr_d1_q;
   logic [ACC_W-1:0] acc_q;

   // Address walk plus the delayed enable/address that line up with returned data.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         en_d1_q   <= 1'b0;
         addr_d1_q <= '0;
         acc_q     <= '0;
      end else begin
         en_d1_q   <= rd_en_q;
         addr_d1_q <= addr_q;
         if (start_i) begin
            rd_en_q <= 1'b1;
            addr_q  <= '0;
         end else if (rd_en_q) begin
            if (addr_q == LAST_ADDR) begin
               rd_en_q <= 1'b0;
               addr_q  <= '0;
            end else begin
               addr_q  <= addr_q + AW'(1);
            end
         end else begin
            rd_en_q <= rd_en_q;
            addr_q  <= addr_q;
         end
         if (start_i) begin
            acc_q <= '0;
         end else if (en_d1_q && spk_i[addr_d1_q]) begin
            acc_q <= acc_q + ACC_W'(rd_data_i);
         end else begin
            acc_q <= acc_q;
         end
      end
   end

   assign rd_en_o   = rd_en_q;
   assign rd_addr_o = addr_q;
   assign last_o    = rd_en_q && (addr_q == LAST_ADDR);
   assign done_o    = en_d1_q && (addr_d1_q == LAST_ADDR);
   assign acc_o     = acc_q;

endmodule

// File: rtl/lif_neuron_reader.sv
// Leaky integrate-and-fire postsynaptic neuron: per accepted timestep it sums the
// weights of spiking synapses, leaks and updates the membrane, and may fire.
module lif_neuron_reader #(
   parameter int N_SYN         = snn_pkg::N_SYN,
   parameter int W_W           = snn_pkg::W_W,
   parameter int V_W           = 10,
   parameter int THRESH        = 64,
   parameter int LEAK          = 2,
   parameter int V_RESET       = 0,
   parameter int REFRACT_STEPS = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   lif_neuron_reader_if.slave  bus
);
   import snn_pkg::*;

   localparam int ACC_W = $clog2(N_SYN * ((1 << W_W) - 1) + 1);
   localparam int RW    = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
   localparam int unsigned V_MAX = (1 << V_W) - 1;

   lif_state_t       state_q;
   logic             ready_q;
   logic             post_q;
   logic [V_W-1:0]   membrane_q;
   logic [RW-1:0]    refr_q;
   logic             refr_flag_q;
   logic [N_SYN-1:0] spk_q;

   logic             accept_s;
   logic             start_s;
   logic             scan_last_s;
   logic             scan_done_s;
   logic [ACC_W-1:0] acc_s;
   logic [31:0]      v_next_d;
   logic             fire_s;

   assign accept_s = bus.step_valid && ready_q;
   assign start_s  = accept_s && (refr_q == RW'(0));

   weight_scan_acc #(
      .N_SYN (N_SYN),
      .W_W   (W_W),
      .ACC_W (ACC_W)
   ) u_scan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_s),
      .spk_i     (spk_q),
      .rd_en_o   (bus.weight_rd_en),
      .rd_addr_o (bus.weight_rd_addr),
      .rd_data_i (bus.weight_rd_data),
      .last_o    (scan_last_s),
      .done_o    (scan_done_s),
      .acc_o     (acc_s)
   );

   // Leak is floored at zero before the synaptic sum is added, then saturated.
   always_comb begin
      v_next_d = sat_add(floor_sub(32'(membrane_q), 32'(LEAK)), 32'(acc_s), 32'(V_MAX));
      fire_s   = (v_next_d >= 32'(THRESH));
   end

   // Timestep sequencer with registered membrane, spike and status outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         post_q      <= 1'b0;
         membrane_q  <= '0;
         refr_q      <= '0;
         refr_flag_q <= 1'b0;
         spk_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               post_q <= 1'b0;
               if (accept_s) begin
                  spk_q   <= bus.pre_spikes;
                  ready_q <= 1'b0;
                  state_q <= (refr_q == RW'(0)) ? SCAN : REFR;
               end else begin
                  state_q <= IDLE;
               end
            end
            SCAN: begin
               if (scan_last_s) begin
                  state_q <= DRAIN;
               end else begin
                  state_q <= SCAN;
               end
            end
            DRAIN: begin
               if (scan_done_s) begin
                  state_q <= UPDATE;
               end else begin
                  state_q <= DRAIN;
               end
            end
            UPDATE: begin
               if (fire_s) begin
                  post_q      <= 1'b1;
                  membrane_q  <= V_W'(V_RESET);
                  refr_q      <= RW'(REFRACT_STEPS);
                  refr_flag_q <= (REFRACT_STEPS != 0);
               end else begin
                  post_q      <= 1'b0;
                  membrane_q  <= v_next_d[V_W-1:0];
               end
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            REFR: begin
               post_q      <= 1'b0;
               refr_q      <= refr_q - RW'(1);
               refr_flag_q <= (refr_q != RW'(1));
               ready_q     <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               post_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.step_ready = ready_q;
   assign bus.post_spike = post_q;
   assign bus.membrane   = membrane_q;
   assign bus.refractory = refr_flag_q;

endmodule

// File: tb/tb_lif_neuron_reader.sv
// Directed bench for lif_neuron_reader: default instance plus a 6-bit membrane
// instance with THRESH=63 for the saturation case.
module tb_lif_neuron_reader;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [3:0] wmem  [16];
   logic [3:0] wmem6 [16];

   lif_neuron_reader_if #(.N_SYN(16), .W_W(4), .V_W(10)) bus ();
   lif_neuron_reader_if #(.N_SYN(16), .W_W(4), .V_W(6))  bus6 ();

   lif_neuron_reader u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   lif_neuron_reader #(.V_W(6), .THRESH(63)) u_dut6 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.weight_rd_en) bus.weight_rd_data <= wmem[bus.weight_rd_addr];
      if (bus6.weight_rd_en) bus6.weight_rd_data <= wmem6[bus6.weight_rd_addr];
   end

   // Present a step and return in the cycle right after the accepting edge.
   task automatic start_step(input logic [15:0] pre);
      int n;
      bus.step_valid = 1'b1;
      bus.pre_spikes = pre;
      n = 0;
      while (bus.step_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL accept_timeout: step_ready=%b after %0d cycles, required 1", bus.step_ready, n);
      end
      @(negedge clk);
      bus.step_valid = 1'b0;
      bus.pre_spikes = ~pre;
   endtask

   // Full scanning step; ends in the cycle where the update is visible.
   task automatic run_step(input logic [15:0] pre);
      start_step(pre);
      repeat (18) @(negedge clk);
   endtask

   task automatic pulse_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.step_valid = 1'b0;  bus.pre_spikes = 16'h0000;
      bus6.step_valid = 1'b0; bus6.pre_spikes = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (bus.step_ready !== 1'b1 || bus.weight_rd_en !== 1'b0 || bus.weight_rd_addr !== 4'd0) begin
         bad++;
         $display("FAIL reset_ctrl: ready=%b rd_en=%b addr=%0d, required 1 0 0",
                  bus.step_ready, bus.weight_rd_en, bus.weight_rd_addr);
      end
      total++;
      if (bus.membrane !== 10'd0 || bus.post_spike !== 1'b0 || bus.refractory !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: membrane=%0d post=%b refr=%b, required 0 0 0",
                  bus.membrane, bus.post_spike, bus.refractory);
      end
      @(negedge clk);
   endtask

   task automatic test_accumulate;
      int exp_m [4] = '{15, 28, 41, 54};
      for (int i = 0; i < 16; i++) wmem[i] = 4'd7;
      wmem[0] = 4'd15;
      for (int s = 0; s < 4; s++) begin
         start_step(16'h0001);
         total++;
         if (bus.weight_rd_en !== 1'b1 || bus.weight_rd_addr !== 4'd0) begin
            bad++;
            $display("FAIL first_read: rd_en=%b addr=%0d, required 1 0", bus.weight_rd_en, bus.weight_rd_addr);
         end
         repeat (17) @(negedge clk);
         total++;
         if (bus.step_ready !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: step_ready=%b one cycle before update, required 0", bus.step_ready);
         end
         @(negedge clk);
         total++;
         if (bus.membrane !== 10'(exp_m[s]) || bus.post_spike !== 1'b0 || bus.step_ready !== 1'b1) begin
            bad++;
            $display("FAIL accumulate_%0d: membrane=%0d post=%b ready=%b, required %0d 0 1",
                     s, bus.membrane, bus.post_spike, bus.step_ready, exp_m[s]);
         end
      end
   endtask

   task automatic test_reset_mid_scan;
      logic seen_spike;
      logic seen_rd;
      start_step(16'h0001);
      repeat (4) @(negedge clk);
      total++;
      if (bus.weight_rd_en !== 1'b1 || bus.weight_rd_addr !== 4'd4) begin
         bad++;
         $display("FAIL mid_scan_addr: rd_en=%b addr=%0d, required 1 4", bus.weight_rd_en, bus.weight_rd_addr);
      end
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (bus.weight_rd_en !== 1'b0 || bus.membrane !== 10'd0 ||
          bus.step_ready !== 1'b1 || bus.post_spike !== 1'b0) begin
         bad++;
         $display("FAIL mid_scan_reset: rd_en=%b membrane=%0d ready=%b post=%b, required 0 0 1 0",
                  bus.weight_rd_en, bus.membrane, bus.step_ready, bus.post_spike);
      end
      rst_n = 1'b1;
      seen_spike = 1'b0;
      seen_rd = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.post_spike === 1'b1) seen_spike = 1'b1;
         if (bus.weight_rd_en === 1'b1) seen_rd = 1'b1;
      end
      total++;
      if (seen_spike !== 1'b0 || seen_rd !== 1'b0) begin
         bad++;
         $display("FAIL mid_scan_abort: spike_seen=%b rd_seen=%b, required 0 0", seen_spike, seen_rd);
      end
   endtask

   task automatic test_floor;
      for (int i = 0; i < 16; i++) wmem[i] = 4'd9;
      wmem[0] = 4'd1;
      run_step(16'h0001);
      total++;
      if (bus.membrane !== 10'd1) begin
         bad++;
         $display("FAIL floor_from_zero: membrane=%0d, required 1", bus.membrane);
      end
      run_step(16'h0000);
      total++;
      if (bus.membrane !== 10'd0 || bus.post_spike !== 1'b0) begin
         bad++;
         $display("FAIL floor_leak: membrane=%0d post=%b, required 0 0", bus.membrane, bus.post_spike);
      end
   endtask

   task automatic test_fire;
      for (int i = 0; i < 16; i++) wmem[i] = 4'd4;
      start_step(16'hFFFF);
      repeat (17) @(negedge clk);
      total++;
      if (bus.post_spike !== 1'b0) begin
         bad++;
         $display("FAIL fire_early: post=%b, required 0", bus.post_spike);
      end
      @(negedge clk);
      total++;
      if (bus.post_spike !== 1'b1 || bus.membrane !== 10'd0 || bus.refractory !== 1'b1) begin
         bad++;
         $display("FAIL fire_equal: post=%b membrane=%0d refr=%b, required 1 0 1",
                  bus.post_spike, bus.membrane, bus.refractory);
      end
      @(negedge clk);
      total++;
      if (bus.post_spike !== 1'b0) begin
         bad++;
         $display("FAIL fire_pulse_width: post=%b, required 0", bus.post_spike);
      end
   endtask

   task automatic test_refractory;
      for (int s = 0; s < 2; s++) begin
         start_step(16'hFFFF);
         total++;
         if (bus.weight_rd_en !== 1'b0 || bus.step_ready !== 1'b0) begin
            bad++;
            $display("FAIL refr_step%0d_busy: rd_en=%b ready=%b, required 0 0", s, bus.weight_rd_en, bus.step_ready);
         end
         @(negedge clk);
         total++;
         if (bus.step_ready !== 1'b1 || bus.weight_rd_en !== 1'b0 || bus.post_spike !== 1'b0 ||
             bus.refractory !== ((s == 0) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL refr_step%0d_done: ready=%b rd_en=%b post=%b refr=%b, required 1 0 0 %0d",
                     s, bus.step_ready, bus.weight_rd_en, bus.post_spike, bus.refractory, (s == 0) ? 1 : 0);
         end
      end
      start_step(16'hFFFF);
      total++;
      if (bus.weight_rd_en !== 1'b1) begin
         bad++;
         $display("FAIL refr_over_scan: rd_en=%b, required 1", bus.weight_rd_en);
      end
      repeat (18) @(negedge clk);
      total++;
      if (bus.post_spike !== 1'b1 || bus.membrane !== 10'd0) begin
         bad++;
         $display("FAIL refr_over_fire: post=%b membrane=%0d, required 1 0", bus.post_spike, bus.membrane);
      end
   endtask

   task automatic test_saturate;
      int n;
      for (int i = 0; i < 16; i++) wmem6[i] = 4'd15;
      bus6.step_valid = 1'b1;
      bus6.pre_spikes = 16'hFFFF;
      n = 0;
      while (bus6.step_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL sat_accept_timeout: step_ready=%b, required 1", bus6.step_ready);
      end
      @(negedge clk);
      bus6.step_valid = 1'b0;
      bus6.pre_spikes = 16'h0000;
      repeat (17) @(negedge clk);
      total++;
      if (bus6.post_spike !== 1'b0 || bus6.membrane !== 6'd0) begin
         bad++;
         $display("FAIL sat_before: post=%b membrane=%0d, required 0 0", bus6.post_spike, bus6.membrane);
      end
      @(negedge clk);
      total++;
      if (bus6.post_spike !== 1'b1 || bus6.membrane !== 6'd0 || bus6.refractory !== 1'b1) begin
         bad++;
         $display("FAIL sat_fire: post=%b membrane=%0d refr=%b, required 1 0 1",
                  bus6.post_spike, bus6.membrane, bus6.refractory);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] plan  [3] = '{16'h0003, 16'h8001, 16'h00F0};
      int          exp_m [3] = '{1, 15, 35};
      int k;
      int last_cyc;
      int exp_addr;
      logic addr_bad;
      pulse_reset();
      for (int i = 0; i < 16; i++) wmem[i] = 4'(i);
      bus.step_valid = 1'b1;
      k = 0;
      last_cyc = 0;
      exp_addr = 0;
      addr_bad = 1'b0;
      for (int cyc = 0; cyc < 120 && k <= 3; cyc++) begin
         if (bus.weight_rd_en === 1'b1) begin
            if (bus.weight_rd_addr !== 4'(exp_addr)) addr_bad = 1'b1;
            exp_addr++;
         end
         if (bus.step_ready === 1'b1) begin
            if (k > 0) begin
               total++;
               if (bus.membrane !== 10'(exp_m[k-1])) begin
                  bad++;
                  $display("FAIL b2b_membrane_%0d: membrane=%0d, required %0d", k-1, bus.membrane, exp_m[k-1]);
               end
               total++;
               if (exp_addr != 16 || addr_bad) begin
                  bad++;
                  $display("FAIL b2b_addr_seq_%0d: reads=%0d order_error=%b, required 16 0", k-1, exp_addr, addr_bad);
               end
               total++;
               if (cyc - last_cyc != 19) begin
                  bad++;
                  $display("FAIL b2b_spacing_%0d: spacing=%0d, required 19", k-1, cyc - last_cyc);
               end
            end
            if (k < 3) begin
               bus.pre_spikes = plan[k];
            end else begin
               bus.step_valid = 1'b0;
            end
            last_cyc = cyc;
            k++;
            exp_addr = 0;
            addr_bad = 1'b0;
         end else begin
            bus.pre_spikes = 16'($urandom);
         end
         @(negedge clk);
      end
      if (k <= 3) begin
         total++; bad++;
         $display("FAIL b2b_timeout: steps=%0d, required 3", k);
      end
      bus.step_valid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_accumulate();
      test_reset_mid_scan();
      test_floor();
      test_fire();
      test_refractory();
      test_saturate();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
